dht11_uart_report: RTL and testbench

Downstream consumer of the DHT11 front-end's BCD outputs. On each new-sample strobe it captures the four temperature/humidity digits. It formats them into a fixed 13-byte ASCII report, `T:ttC H:hh%\r\n`. It then serialises the report on an 8N1 UART line, and replaces the disabled serial path of the sensor top level with a self-contained report transmitter.

---
 rtl/dht11_pkg.sv | 66 ++++++
 rtl/dht11_uart_report_uart.sv | 102 ++++++++++
 rtl/dht11_uart_report.sv | 111 +++++++++++
 tb/tb_dht11_uart_report.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dht11_pkg.sv
// Shared constants, state encodings and report formatting for the
// DHT11 UART report transmitter.
package dht11_pkg;

    localparam int FRAME_LEN = 13;

    localparam logic [7:0] CH_T      = 8'h54;
    localparam logic [7:0] CH_COLON  = 8'h3A;
    localparam logic [7:0] CH_C      = 8'h43;
    localparam logic [7:0] CH_SPACE  = 8'h20;
    localparam logic [7:0] CH_H      = 8'h48;
    localparam logic [7:0] CH_PCT    = 8'h25;
    localparam logic [7:0] CH_CR     = 8'h0D;
    localparam logic [7:0] CH_LF     = 8'h0A;
    localparam logic [7:0] CH_QMARK  = 8'h3F;
    localparam logic [7:0] CH_DIGIT0 = 8'h30;

    typedef enum logic [1:0] {
        TOP_IDLE,
        TOP_SEND,
        TOP_DONE
    } top_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef struct packed {
        logic [3:0] t_ten;
        logic [3:0] t_one;
        logic [3:0] h_ten;
        logic [3:0] h_one;
    } digits_t;

    function automatic logic [7:0] ascii_digit(input logic [3:0] d);
        return (d <= 4'd9) ? (CH_DIGIT0 + {4'h0, d}) : CH_QMARK;
    endfunction

    // Byte idx of the report "T:ttC H:hh%\r\n"
    function automatic logic [7:0] report_byte(input logic [3:0] idx,
                                               input digits_t    dg);
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            4'd0:    b = CH_T;
            4'd1:    b = CH_COLON;
            4'd2:    b = ascii_digit(dg.t_ten);
            4'd3:    b = ascii_digit(dg.t_one);
            4'd4:    b = CH_C;
            4'd5:    b = CH_SPACE;
            4'd6:    b = CH_H;
            4'd7:    b = CH_COLON;
            4'd8:    b = ascii_digit(dg.h_ten);
            4'd9:    b = ascii_digit(dg.h_one);
            4'd10:   b = CH_PCT;
            4'd11:   b = CH_CR;
            4'd12:   b = CH_LF;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/dht11_uart_report_uart.sv
// 8N1 transmitter with baud divider; a byte offered on start during the
// last stop-bit cycle is chained with no idle gap.
module uart_tx_core
    import dht11_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       TxD,
    output logic       busy,
    output logic       done
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

    tx_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          txd_q, txd_d;
    logic          busy_q;
    logic          bit_end;

    assign bit_end = (cnt_q == CW'(DIV - 1));
    assign done    = (state_q == TX_STOP) && bit_end;
    assign TxD     = txd_q;
    assign busy    = busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            txd_q   <= txd_d;
            busy_q  <= (state_d != TX_IDLE);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        txd_d   = txd_q;
        if (state_q != TX_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + CW'(1);
        end
        case (state_q)
            TX_IDLE: begin
                if (start) begin
                    state_d = TX_START;
                    sh_d    = data;
                    txd_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    state_d = TX_DATA;
                    txd_d   = sh_q[0];
                    bit_d   = '0;
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = TX_STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        sh_d  = sh_q >> 1;
                        txd_d = sh_q[1];
                    end
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    if (start) begin
                        state_d = TX_START;
                        sh_d    = data;
                        txd_d   = 1'b0;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

endmodule

// File: rtl/dht11_uart_report.sv
// Latches DHT11 BCD digits on a strobe and transmits the 13-byte ASCII
// report "T:ttC H:hh%\r\n" over an 8N1 UART.
module dht11_uart_report
    import dht11_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       data_rdy,
    input  logic [3:0] temperature_ten,
    input  logic [3:0] temperature_one,
    input  logic [3:0] humidity_ten,
    input  logic [3:0] humidity_one,
    output logic       TxD,
    output logic       busy,
    output logic       frame_done,
    output logic [7:0] drop_cnt
);

    localparam int DIV = (CLK_FREQ + BAUD / 2) / BAUD;

    top_state_t state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic [3:0] sel;
    digits_t    dig_q;
    logic [7:0] drop_q;
    logic       accept;
    logic       core_start;
    logic [7:0] core_data;
    logic       core_busy;
    logic       core_done;

    // IDLE and DONE both accept; DONE already shows busy low
    assign accept = data_rdy &&
                    (state_q == TOP_IDLE || state_q == TOP_DONE);

    assign frame_done = (state_q == TOP_DONE);
    assign busy       = core_busy;
    assign drop_cnt   = drop_q;
    assign core_data  = report_byte(sel, dig_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TOP_IDLE;
            idx_q   <= '0;
            dig_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (accept) begin
                dig_q <= '{t_ten: temperature_ten,
                           t_one: temperature_one,
                           h_ten: humidity_ten,
                           h_one: humidity_one};
            end
            if (data_rdy && !accept && drop_q != 8'hFF) begin
                drop_q <= drop_q + 8'd1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        core_start = 1'b0;
        sel        = idx_q;
        case (state_q)
            TOP_IDLE: begin
                if (accept) begin
                    state_d = TOP_SEND;
                    idx_d   = '0;
                end
            end
            TOP_SEND: begin
                if (!core_busy) begin
                    core_start = 1'b1;
                end else if (core_done) begin
                    if (idx_q == 4'(FRAME_LEN - 1)) begin
                        state_d = TOP_DONE;
                    end else begin
                        // chain next byte into the final stop-bit cycle
                        core_start = 1'b1;
                        sel        = idx_q + 4'd1;
                        idx_d      = idx_q + 4'd1;
                    end
                end
            end
            TOP_DONE: begin
                state_d = accept ? TOP_SEND : TOP_IDLE;
                idx_d   = '0;
            end
            default: state_d = TOP_IDLE;
        endcase
    end

    uart_tx_core #(
        .DIV(DIV)
    ) u_tx (
        .clk  (clk),
        .rst_n(rst_n),
        .start(core_start),
        .data (core_data),
        .TxD  (TxD),
        .busy (core_busy),
        .done (core_done)
    );

endmodule

// File: tb/tb_dht11_uart_report.sv
// Scoreboard bench: stimulus queues expected report bytes, a UART
// receiver monitor decodes the line and checks them.
module tb_dht11_uart_report;

    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 100_000;
    localparam int DIV      = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       data_rdy = 1'b0;
    logic [3:0] tt = '0, to = '0, ht = '0, ho = '0;
    logic       TxD, busy, frame_done;
    logic [7:0] drop_cnt;

    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         exp_drop = 0;
    int         pushed = 0;
    int         rx_count = 0;
    logic [7:0] exp_q[$];

    dht11_uart_report #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_rdy       (data_rdy),
        .temperature_ten(tt),
        .temperature_one(to),
        .humidity_ten   (ht),
        .humidity_one   (ho),
        .TxD            (TxD),
        .busy           (busy),
        .frame_done     (frame_done),
        .drop_cnt       (drop_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h (cycle %0d)",
                     nm, got, want, cyc);
        end
    endtask

    function automatic logic [7:0] glyph(input int d);
        return (d < 10) ? 8'(48 + d) : "?";
    endfunction

    task automatic push_report(input int a, input int b,
                               input int c, input int d);
        logic [7:0] r[13];
        r = '{"T", ":", glyph(a), glyph(b), "C", " ", "H", ":",
              glyph(c), glyph(d), "%", 8'd13, 8'd10};
        foreach (r[i]) exp_q.push_back(r[i]);
        pushed += 13;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // called #1 after an edge; returns #1 after the sampling edge
    task automatic pulse(input int a, input int b, input int c,
                         input int d);
        data_rdy = 1'b1;
        tt = 4'(a); to = 4'(b); ht = 4'(c); ho = 4'(d);
        @(posedge clk);
        #1;
        data_rdy = 1'b0;
    endtask

    task automatic accept_frame(input int a, input int b, input int c,
                                input int d, output int n);
        pulse(a, b, c, d);
        n = cyc;
        push_report(a, b, c, d);
    endtask

    task automatic drop_one();
        pulse($urandom_range(0, 15), $urandom_range(0, 15),
              $urandom_range(0, 15), $urandom_range(0, 15));
        exp_drop = (exp_drop < 255) ? exp_drop + 1 : 255;
    endtask

    task automatic rand_frame(output int n);
        accept_frame($urandom_range(0, 15), $urandom_range(0, 9),
                     $urandom_range(0, 9), $urandom_range(0, 15), n);
    endtask

    task automatic rx(output logic ok, output logic [7:0] b,
                      output logic stopb);
        ok = 1'b0;
        b = '0;
        stopb = 1'b0;
        repeat (DIV / 2) @(negedge clk);
        if (rst_n !== 1'b1 || TxD !== 1'b0) return;
        for (int i = 0; i < 8; i++) begin
            repeat (DIV) @(negedge clk);
            if (rst_n !== 1'b1) return;
            b[i] = TxD;
        end
        repeat (DIV) @(negedge clk);
        if (rst_n !== 1'b1) return;
        stopb = TxD;
        ok = 1'b1;
    endtask

    initial begin : monitor
        logic       ok, stopb;
        logic [7:0] b, w;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && TxD === 1'b0) begin
                rx(ok, b, stopb);
                if (ok) begin
                    rx_count++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rx_extra got %02h want none", b);
                    end else begin
                        w = exp_q.pop_front();
                        chk("rx_byte", b, w);
                        chk("rx_stop", stopb, 1'b1);
                    end
                end
            end
        end
    end

    initial begin : stim
        int n, m, bc, fd_at;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_txd", TxD, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", frame_done, 1'b0);
        chk("rst_drop", drop_cnt, 8'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // basic frame with timing
        accept_frame(2, 3, 4, 5, n);
        bc = 0;
        fd_at = 0;
        for (int k = 1; k <= 1301; k++) begin
            wait_to(n + k);
            if (k == 1) chk("first_start", TxD, 1'b0);
            if (busy) bc++;
            if (frame_done && fd_at == 0) begin
                fd_at = k;
                chk("done_busy", busy, 1'b0);
            end
        end
        chk("busy_len", bc, 1300);
        chk("done_at", fd_at, 1301);
        wait_to(n + 1302);
        chk("done_pulse", frame_done, 1'b0);
        wait_to(n + 1305);

        // non-BCD digit
        accept_frame(12, 0, 0, 0, n);
        wait_to(n + 1305);

        // drops and mid-frame digit changes
        accept_frame(1, 9, 6, 7, n);
        wait_to(n + 20);
        drop_one();
        wait_to(n + 40);
        drop_one();
        wait_to(n + 60);
        drop_one();
        tt = 4'($urandom_range(0, 15));
        ho = 4'($urandom_range(0, 15));
        wait_to(n + 70);
        chk("drop3", drop_cnt, exp_drop);
        wait_to(n + 700);
        to = 4'($urandom_range(0, 15));
        ht = 4'($urandom_range(0, 15));
        wait_to(n + 1301);
        chk("done_cycle", frame_done, 1'b1);

        // strobe in the frame_done cycle
        rand_frame(m);
        chk("drop_keep", drop_cnt, exp_drop);
        wait_to(m + 1);
        chk("chain_start", TxD, 1'b0);
        chk("chain_busy", busy, 1'b1);

        // asynchronous reset mid-frame
        wait_to(m + 500);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_txd", TxD, 1'b1);
        chk("arst_busy", busy, 1'b0);
        chk("arst_drop", drop_cnt, 8'd0);
        exp_drop = 0;
        pushed -= exp_q.size();
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rand_frame(n);
        wait_to(n + 1305);

        // drop counter saturation across two frames
        rand_frame(n);
        for (int k = 0; k < 150; k++) begin
            wait_to(n + 10 + 4 * k);
            drop_one();
        end
        chk("drop150", drop_cnt, exp_drop);
        wait_to(n + 1301);
        rand_frame(m);
        for (int k = 0; k < 150; k++) begin
            wait_to(m + 10 + 4 * k);
            drop_one();
        end
        chk("drop_sat", drop_cnt, 8'd255);
        wait_to(m + 1305);

        repeat (3) begin
            rand_frame(n);
            wait_to(n + 1305);
        end

        repeat (50) @(posedge clk);
        #1;
        chk("q_empty", exp_q.size(), 0);
        chk("rx_total", rx_count, pushed);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
